key_search_ctrl: RTL

Sequencer that performs a brute-force key search by driving one shared decryptor instance (64-bit block, 128-bit key). It issues candidate keys from a programmed range, one decryption in flight at a time. Each decrypted header is compared against an expected plaintext under a mask. It reports the first matching key, or exhaustion of the range. It sits between the top-level key-breaking wrapper and the synchronous decryptor.

---
 rtl/key_search_pkg.sv | 26 ++
 rtl/key_range_counter.sv | 37 +++
 rtl/key_search_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/key_search_pkg.sv
// rtl/key_search_pkg.sv - shared types, default widths and header match function for the key search sequencer
package key_search_pkg;

    localparam int KEY_W_DEF = 128;
    localparam int BLK_W_DEF = 64;
    localparam int CNT_W_DEF = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_CHECK,
        ST_FINISH
    } state_t;

    // A header matches when every bit selected by mask agrees with expected.
    // mask == 0 therefore matches any decrypted block.
    function automatic logic hdr_match(
        input logic [BLK_W_DEF-1:0] plain,
        input logic [BLK_W_DEF-1:0] expected,
        input logic [BLK_W_DEF-1:0] mask
    );
        return ((plain ^ expected) & mask) == '0;
    endfunction

endpackage

// File: rtl/key_range_counter.sv
// rtl/key_range_counter.sv - candidate key register with load, increment and end-of-range flag
//   clk, rst     : clock, asynchronous active-low reset
//   load/load_val: load first candidate
//   inc          : advance to the next candidate
//   key_hi       : last candidate of the range (inclusive)
//   cur          : current candidate
//   last         : cur is the last candidate of the range
module key_range_counter
    import key_search_pkg::*;
#(
    parameter int KEY_W = KEY_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [KEY_W-1:0] load_val,
    input  logic             inc,
    input  logic [KEY_W-1:0] key_hi,
    output logic [KEY_W-1:0] cur,
    output logic             last
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur <= '0;
        end else if (load) begin
            cur <= load_val;
        end else if (inc) begin
            cur <= cur + 1'b1;
        end
    end

    // The end test is made on cur before any increment, so a range ending at
    // all-ones terminates instead of wrapping to zero.
    assign last = (cur == key_hi);

endmodule

// File: rtl/key_search_ctrl.sv
// rtl/key_search_ctrl.sv - brute-force key search sequencer driving one shared decryptor
//   clk, rst                 : clock, asynchronous active-low reset
//   start, abort             : begin search (IDLE only) / stop search
//   key_lo, key_hi           : inclusive candidate range
//   header, expected, mask   : encrypted header, expected plaintext, compare mask
//   dec_ready/dec_start      : decryptor handshake, one job in flight
//   dec_key, dec_block       : job operands, held until dec_done
//   dec_done, dec_plain      : decryptor result
//   busy, done, found        : search status
//   proper_key, attempts     : matching key, candidates completed
module key_search_ctrl
    import key_search_pkg::*;
#(
    parameter int KEY_W = KEY_W_DEF,
    parameter int BLK_W = BLK_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [KEY_W-1:0] key_lo,
    input  logic [KEY_W-1:0] key_hi,
    input  logic [BLK_W-1:0] header,
    input  logic [BLK_W-1:0] expected,
    input  logic [BLK_W-1:0] mask,
    input  logic             dec_ready,
    output logic             dec_start,
    output logic [KEY_W-1:0] dec_key,
    output logic [BLK_W-1:0] dec_block,
    input  logic             dec_done,
    input  logic [BLK_W-1:0] dec_plain,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [KEY_W-1:0] proper_key,
    output logic [CNT_W-1:0] attempts
);

    state_t           state, state_nxt;
    logic [KEY_W-1:0] key_hi_q;
    logic [BLK_W-1:0] expected_q;
    logic [BLK_W-1:0] mask_q;
    logic [BLK_W-1:0] plain_q;
    logic             cur_last;
    logic             match;
    logic             take_start;
    logic             go_abort;
    logic             cnt_inc;

    // abort only has an effect once a search is under way; in IDLE it simply
    // blocks a simultaneous start.
    assign go_abort   = abort && (state != ST_IDLE);
    assign take_start = (state == ST_IDLE) && start && !abort;
    assign match      = hdr_match(plain_q, expected_q, mask_q);
    assign cnt_inc    = (state == ST_CHECK) && !abort && !match && !cur_last;

    key_range_counter #(
        .KEY_W (KEY_W)
    ) u_range (
        .clk      (clk),
        .rst      (rst),
        .load     (take_start),
        .load_val (key_lo),
        .inc      (cnt_inc),
        .key_hi   (key_hi_q),
        .cur      (dec_key),
        .last     (cur_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (take_start) begin
                    state_nxt = (key_lo > key_hi) ? ST_FINISH : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                busy = 1'b1;
                if (dec_ready) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                busy = 1'b1;
                if (dec_done) begin
                    state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                busy = 1'b1;
                state_nxt = (match || cur_last) ? ST_FINISH : ST_ISSUE;
            end
            ST_FINISH: begin
                done      = !abort;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        if (go_abort) begin
            state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_hi_q   <= '0;
            dec_block  <= '0;
            expected_q <= '0;
            mask_q     <= '0;
            plain_q    <= '0;
            dec_start  <= 1'b0;
            found      <= 1'b0;
            proper_key <= '0;
            attempts   <= '0;
        end else begin
            // Registered job pulse: fires in the first WAIT cycle, so the
            // decryptor sees it two cycles after the start pulse.
            dec_start <= (state == ST_ISSUE) && dec_ready && !abort;

            if (take_start) begin
                key_hi_q   <= key_hi;
                dec_block  <= header;
                expected_q <= expected;
                mask_q     <= mask;
                found      <= 1'b0;
                proper_key <= '0;
                attempts   <= '0;
            end

            if ((state == ST_WAIT) && dec_done && !abort) begin
                plain_q <= dec_plain;
            end

            if ((state == ST_CHECK) && !abort) begin
                if (attempts != '1) begin
                    attempts <= attempts + 1'b1;
                end
                if (match) begin
                    found      <= 1'b1;
                    proper_key <= dec_key;
                end
            end

            if (go_abort) begin
                found <= 1'b0;
            end
        end
    end

endmodule
